// File: rtl/axi_dma_r_pkg.sv
// Shared AXI/MIG widths and response codes for the DMA read engine.
package axi_dma_r_pkg;

    localparam int unsigned DDR_ADDR_W  = 32;
    localparam int unsigned MIG_BUS_W   = 32;
    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_LOCK_W  = 1;
    localparam int unsigned AXI_CACHE_W = 4;
    localparam int unsigned AXI_PROT_W  = 3;
    localparam int unsigned AXI_QOS_W   = 4;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_MODIF = 4'h2;
    localparam logic [AXI_PROT_W-1:0]  AXI_PROT_NSEC   = 3'b010;

    // Bytes-per-beat encoding for arsize.
    function automatic logic [AXI_SIZE_W-1:0] axi_size(input int unsigned bus_w);
        return AXI_SIZE_W'($clog2(bus_w / 8));
    endfunction

endpackage

// File: rtl/axi_dma_r.sv
// Burst-read DMA master: one client request becomes one AXI4 INCR read burst,
// each returned beat is strobed out with `ready`; bad responses/rlast set `error`.
module axi_dma_r
    import axi_dma_r_pkg::*;
#(
    parameter int unsigned BURST_BEATS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid,
    input  logic [DDR_ADDR_W-1:0]  addr,
    output logic                   ready,
    output logic [MIG_BUS_W-1:0]   rdata,
    output logic                   error,
    output logic [AXI_ID_W-1:0]    m_axi_arid,
    output logic [DDR_ADDR_W-1:0]  m_axi_araddr,
    output logic [AXI_LEN_W-1:0]   m_axi_arlen,
    output logic [AXI_SIZE_W-1:0]  m_axi_arsize,
    output logic [AXI_BURST_W-1:0] m_axi_arburst,
    output logic [AXI_LOCK_W-1:0]  m_axi_arlock,
    output logic [AXI_CACHE_W-1:0] m_axi_arcache,
    output logic [AXI_PROT_W-1:0]  m_axi_arprot,
    output logic [AXI_QOS_W-1:0]   m_axi_arqos,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [AXI_ID_W-1:0]    m_axi_rid,
    input  logic [MIG_BUS_W-1:0]   m_axi_rdata,
    input  logic [AXI_RESP_W-1:0]  m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);

    localparam int unsigned CNT_W = AXI_LEN_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_BEATS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DDR_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  error_q, error_d;
    logic                  ready_q, ready_d;
    logic [MIG_BUS_W-1:0]  rdata_q, rdata_d;
    logic                  last_cnt;

    // Read ID is not used: only one burst is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^m_axi_rid;

    assign last_cnt = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        error_d = error_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (valid) begin
                    addr_d  = addr;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (m_axi_arready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (m_axi_rvalid) begin
                    ready_d = 1'b1;
                    rdata_d = m_axi_rdata;
                    cnt_d   = cnt_q + 1'b1;
                    // Early rlast or missing rlast on the final beat are both misalignment.
                    if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_cnt)) begin
                        pend_d = 1'b1;
                    end
                    if (m_axi_rlast || last_cnt) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                error_d = pend_q;
                pend_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            error_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            error_q <= error_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready         = ready_q;
    assign rdata         = rdata_q;
    assign error         = error_q;
    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = AXI_LEN_W'(BURST_BEATS - 1);
    assign m_axi_arsize  = axi_size(MIG_BUS_W);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = '0;
    assign m_axi_arcache = AXI_CACHE_MODIF;
    assign m_axi_arprot  = AXI_PROT_NSEC;
    assign m_axi_arqos   = '0;
    assign m_axi_arvalid = (state_q == StAddr);
    assign m_axi_rready  = (state_q == StData);

endmodule
